noc_dmem_responder: RTL and testbench

Network-side memory responder: the target end of the remote data-memory protocol that per-core routers initiate. It accepts single-flit request packets from the local port of a NoC router and replays each one on an SCR1-style dmem bus toward the local memory. It then returns a single-flit response packet to the requesting node. One request is in flight at a time; it sits between a router local port and a node's shared data memory.

---
 rtl/noc_dmem_responder.sv | 159 +++++++++++++++
 tb/tb_noc_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_dmem_responder.sv
// Network-side data-memory responder: takes one request flit from the router local port,
// replays it on the dmem bus, and returns a single response flit to the requester.
module noc_dmem_responder #(
   parameter int unsigned NODE_ID         = 0,
   parameter int unsigned NODE_COUNT      = 9,
   parameter int unsigned PACKET_ID_WIDTH = 5,
   parameter int unsigned TIMEOUT         = 256,
   localparam int unsigned NODE_W = ($clog2(NODE_COUNT) > 1) ? $clog2(NODE_COUNT) : 1,
   localparam int unsigned REQ_W  = 2 * NODE_W + PACKET_ID_WIDTH + 67,
   localparam int unsigned RSP_W  = 2 * NODE_W + PACKET_ID_WIDTH + 33
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REQ_W-1:0] pkt_in,
   input  logic             pkt_in_valid,
   output logic             pkt_in_ready,
   output logic [RSP_W-1:0] pkt_out,
   output logic             pkt_out_valid,
   input  logic             pkt_out_ready,
   output logic             mem_req_o,
   output logic             mem_cmd_o,
   output logic [1:0]       mem_width_o,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   input  logic             mem_req_ack_i,
   input  logic [31:0]      mem_rdata_i,
   input  logic [1:0]       mem_resp_i
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);
   localparam logic [NODE_W-1:0] NodeId = NODE_W'(NODE_ID);
   localparam logic [CNT_W-1:0]  CntLast = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StSend} state_e;

   state_e                     state_q, state_d;
   logic [NODE_W-1:0]          src_q, src_d;
   logic [PACKET_ID_WIDTH-1:0] pid_q, pid_d;
   logic                       cmd_q, cmd_d;
   logic [1:0]                 width_q, width_d;
   logic [31:0]                addr_q, addr_d;
   logic [31:0]                wdata_q, wdata_d;
   logic                       err_q, err_d;
   logic [31:0]                rdata_q, rdata_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;

   logic [NODE_W-1:0]          in_dst, in_src;
   logic [PACKET_ID_WIDTH-1:0] in_pid;
   logic                       in_cmd;
   logic [1:0]                 in_width;
   logic [31:0]                in_addr, in_wdata;
   logic                       in_bad;

   assign in_wdata = pkt_in[31:0];
   assign in_addr  = pkt_in[63:32];
   assign in_width = pkt_in[65:64];
   assign in_cmd   = pkt_in[66];
   assign in_pid   = pkt_in[67 +: PACKET_ID_WIDTH];
   assign in_src   = pkt_in[67 + PACKET_ID_WIDTH +: NODE_W];
   assign in_dst   = pkt_in[67 + PACKET_ID_WIDTH + NODE_W +: NODE_W];

   // Misrouted, reserved-width or misaligned requests never reach memory.
   always_comb begin
      in_bad = (in_dst != NodeId) ||
               (in_width == 2'd3) ||
               ((in_width == 2'd1) && in_addr[0]) ||
               ((in_width == 2'd2) && (in_addr[1:0] != 2'b00));
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      pid_d   = pid_q;
      cmd_d   = cmd_q;
      width_d = width_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (pkt_in_valid) begin
               src_d   = in_src;
               pid_d   = in_pid;
               cmd_d   = in_cmd;
               width_d = in_width;
               addr_d  = in_addr;
               wdata_d = in_wdata;
               rdata_d = '0;
               cnt_d   = '0;
               err_d   = in_bad;
               state_d = in_bad ? StSend : StReq;
            end
         end
         StReq: begin
            if (mem_req_ack_i) begin
               cnt_d   = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mem_resp_i == 2'd1) begin
               err_d   = 1'b0;
               rdata_d = cmd_q ? 32'd0 : mem_rdata_i;
               state_d = StSend;
            end else if (mem_resp_i[1] || (cnt_q == CntLast)) begin
               // ERR, the undefined code 3, and timeout all report an error.
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = StSend;
            end
         end
         StSend: begin
            if (pkt_out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         src_q   <= '0;
         pid_q   <= '0;
         cmd_q   <= 1'b0;
         width_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         pid_q   <= pid_d;
         cmd_q   <= cmd_d;
         width_q <= width_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pkt_in_ready  = (state_q == StIdle);
   assign pkt_out_valid = (state_q == StSend);
   assign pkt_out       = pkt_out_valid ? {src_q, NodeId, pid_q, err_q, rdata_q} : '0;
   assign mem_req_o     = (state_q == StReq);
   assign mem_cmd_o     = cmd_q;
   assign mem_width_o   = width_q;
   assign mem_addr_o    = addr_q;
   assign mem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_noc_dmem_responder.sv
// Directed bench for noc_dmem_responder: vector table for single transactions plus
// hand-written timeout, backpressure and mid-flight reset sequences.
module tb_noc_dmem_responder;

   localparam int unsigned REQ_W = 80;
   localparam int unsigned RSP_W = 46;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [REQ_W-1:0] pkt_in = '0;
   logic             pkt_in_valid = 1'b0;
   logic             pkt_in_ready;
   logic [RSP_W-1:0] pkt_out;
   logic             pkt_out_valid;
   logic             pkt_out_ready = 1'b0;
   logic             mem_req_o;
   logic             mem_cmd_o;
   logic [1:0]       mem_width_o;
   logic [31:0]      mem_addr_o;
   logic [31:0]      mem_wdata_o;
   logic             mem_req_ack_i = 1'b0;
   logic [31:0]      mem_rdata_i = '0;
   logic [1:0]       mem_resp_i = '0;

   noc_dmem_responder #(
      .NODE_ID        (4),
      .NODE_COUNT     (9),
      .PACKET_ID_WIDTH(5),
      .TIMEOUT        (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pkt_in       (pkt_in),
      .pkt_in_valid (pkt_in_valid),
      .pkt_in_ready (pkt_in_ready),
      .pkt_out      (pkt_out),
      .pkt_out_valid(pkt_out_valid),
      .pkt_out_ready(pkt_out_ready),
      .mem_req_o    (mem_req_o),
      .mem_cmd_o    (mem_cmd_o),
      .mem_width_o  (mem_width_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_req_ack_i(mem_req_ack_i),
      .mem_rdata_i  (mem_rdata_i),
      .mem_resp_i   (mem_resp_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  dst;
      logic [3:0]  src;
      logic [4:0]  pid;
      logic        cmd;
      logic [1:0]  width;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_dly;
      logic [1:0]  resp;
      logic [31:0] mrdata;
      logic        valid_req;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cur     = -1;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL [case %0d] %s: got %0h expected %0h", cur, name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [3:0] dst, input logic [3:0] src,
                               input logic [4:0] pid, input logic cmd,
                               input logic [1:0] width, input logic [31:0] addr,
                               input logic [31:0] wdata, input int ack_dly,
                               input logic [1:0] resp, input logic [31:0] mrdata,
                               input logic valid_req, input logic exp_err,
                               input logic [31:0] exp_rdata);
      vec_t v;
      v.dst = dst; v.src = src; v.pid = pid; v.cmd = cmd; v.width = width;
      v.addr = addr; v.wdata = wdata; v.ack_dly = ack_dly; v.resp = resp;
      v.mrdata = mrdata; v.valid_req = valid_req; v.exp_err = exp_err;
      v.exp_rdata = exp_rdata;
      return v;
   endfunction

   function automatic logic [REQ_W-1:0] req(input vec_t v);
      return {v.dst, v.src, v.pid, v.cmd, v.width, v.addr, v.wdata};
   endfunction

   task automatic run_vec(input vec_t v);
      logic [66:0]      mf;
      logic [RSP_W-1:0] er;
      mf = {v.cmd, v.width, v.addr, v.wdata};
      er = {v.src, 4'd4, v.pid, v.exp_err, v.exp_rdata};
      chk("in_ready_idle", pkt_in_ready, 1);
      pkt_in = req(v);
      pkt_in_valid = 1'b1;
      step();
      pkt_in_valid = 1'b0;
      pkt_in = '0;
      chk("in_ready_busy", pkt_in_ready, 0);
      if (v.valid_req) begin
         for (int i = 0; i <= v.ack_dly; i++) begin
            chk("mem_req_hold", mem_req_o, 1);
            chk("mem_fields", {mem_cmd_o, mem_width_o, mem_addr_o, mem_wdata_o}, mf);
            chk("out_valid_early", pkt_out_valid, 0);
            if (i == v.ack_dly) mem_req_ack_i = 1'b1;
            step();
         end
         mem_req_ack_i = 1'b0;
         chk("mem_req_drop", mem_req_o, 0);
         chk("out_valid_wait", pkt_out_valid, 0);
         mem_resp_i  = v.resp;
         mem_rdata_i = v.mrdata;
         step();
         mem_resp_i  = 2'd0;
         mem_rdata_i = '0;
      end else begin
         chk("no_mem_req", mem_req_o, 0);
      end
      chk("out_valid", pkt_out_valid, 1);
      chk("pkt_out", pkt_out, er);
      pkt_out_ready = 1'b1;
      step();
      pkt_out_ready = 1'b0;
      chk("out_valid_clear", pkt_out_valid, 0);
      chk("in_ready_back", pkt_in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t a, b;
      // Reset state, with a valid request offered while reset is held.
      pkt_in = {4'd4, 4'd2, 5'd1, 1'b0, 2'd2, 32'h100, 32'h0};
      pkt_in_valid = 1'b1;
      repeat (2) step();
      chk("rst_in_ready", pkt_in_ready, 1);
      chk("rst_out_valid", pkt_out_valid, 0);
      chk("rst_pkt_out", pkt_out, 0);
      chk("rst_mem", {mem_req_o, mem_cmd_o, mem_width_o, mem_addr_o, mem_wdata_o}, 0);
      pkt_in_valid = 1'b0;
      pkt_in = '0;
      rst = 1'b0;
      step();

      vecs[0] = mk(4, 2, 7, 0, 2, 32'h100, 0, 0, 1, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF);
      vecs[1] = mk(4, 2, 8, 1, 1, 32'h102, 32'h1234, 5, 1, 32'hFFFFFFFF, 1, 0, 0);
      vecs[2] = mk(4, 1, 1, 0, 2, 32'h101, 0, 0, 0, 0, 0, 1, 0);
      vecs[3] = mk(4, 1, 2, 0, 3, 32'h0, 0, 0, 0, 0, 0, 1, 0);
      vecs[4] = mk(5, 1, 3, 0, 2, 32'h200, 0, 0, 0, 0, 0, 1, 0);
      vecs[5] = mk(4, 6, 4, 0, 0, 32'h103, 0, 1, 2, 32'h55, 1, 1, 0);
      vecs[6] = mk(4, 0, 5, 0, 1, 32'h2, 0, 2, 3, 32'h66, 1, 1, 0);
      vecs[7] = mk(4, 8, 31, 1, 2, 32'h0, 32'hA5A55A5A, 0, 1, 32'h77, 1, 0, 0);
      vecs[8] = mk(4, 3, 6, 0, 1, 32'h1FF, 0, 0, 0, 0, 0, 1, 0);
      vecs[9] = mk(4, 7, 10, 0, 0, 32'h3, 0, 0, 1, 32'hAB, 1, 0, 32'hAB);

      for (int i = 0; i < 10; i++) begin
         cur = i;
         run_vec(vecs[i]);
      end

      // Timeout: ack, no response; error flit 9 cycles after ack, late RDY ignored.
      cur = 100;
      a = mk(4, 2, 11, 0, 2, 32'h300, 0, 0, 0, 0, 1, 1, 0);
      pkt_in = req(a);
      pkt_in_valid = 1'b1;
      step();
      pkt_in_valid = 1'b0;
      mem_req_ack_i = 1'b1;
      step();
      mem_req_ack_i = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         chk("to_no_rsp_yet", pkt_out_valid, 0);
         step();
      end
      chk("to_out_valid", pkt_out_valid, 1);
      chk("to_pkt_out", pkt_out, {4'd2, 4'd4, 5'd11, 1'b1, 32'd0});
      pkt_out_ready = 1'b1;
      step();
      pkt_out_ready = 1'b0;
      mem_resp_i = 2'd1;
      mem_rdata_i = 32'h12345678;
      step();
      mem_resp_i = 2'd0;
      step();
      chk("to_late_rdy_ignored", {pkt_out_valid, pkt_in_ready, mem_req_o}, 3'b010);

      // Backpressure: response held 10 cycles, second request waits for handshake.
      cur = 101;
      a = mk(4, 1, 3, 0, 2, 32'h40, 0, 0, 1, 32'hCAFEF00D, 1, 0, 32'hCAFEF00D);
      b = mk(4, 3, 9, 0, 2, 32'h44, 0, 0, 1, 32'h11223344, 1, 0, 32'h11223344);
      pkt_in = req(a);
      pkt_in_valid = 1'b1;
      step();
      pkt_in = req(b);
      mem_req_ack_i = 1'b1;
      step();
      mem_req_ack_i = 1'b0;
      mem_resp_i = 2'd1;
      mem_rdata_i = 32'hCAFEF00D;
      step();
      mem_resp_i = 2'd0;
      mem_rdata_i = '0;
      for (int k = 0; k < 10; k++) begin
         chk("bp_out_valid", pkt_out_valid, 1);
         chk("bp_pkt_stable", pkt_out, {4'd1, 4'd4, 5'd3, 1'b0, 32'hCAFEF00D});
         chk("bp_in_ready_low", pkt_in_ready, 0);
         step();
      end
      pkt_out_ready = 1'b1;
      step();
      pkt_out_ready = 1'b0;
      chk("bp_in_ready_back", pkt_in_ready, 1);
      chk("bp_second_not_yet", mem_req_o, 0);
      step();
      pkt_in_valid = 1'b0;
      pkt_in = '0;
      chk("bp_second_req", mem_req_o, 1);
      chk("bp_second_addr", mem_addr_o, 32'h44);
      mem_req_ack_i = 1'b1;
      step();
      mem_req_ack_i = 1'b0;
      mem_resp_i = 2'd1;
      mem_rdata_i = 32'h11223344;
      step();
      mem_resp_i = 2'd0;
      mem_rdata_i = '0;
      chk("bp_second_rsp", pkt_out, {4'd3, 4'd4, 5'd9, 1'b0, 32'h11223344});
      pkt_out_ready = 1'b1;
      step();
      pkt_out_ready = 1'b0;

      // Reset while waiting on memory; a later RDY must produce nothing.
      cur = 102;
      a = mk(4, 5, 12, 1, 2, 32'h80, 32'h0BADF00D, 0, 1, 0, 1, 0, 0);
      pkt_in = req(a);
      pkt_in_valid = 1'b1;
      step();
      pkt_in_valid = 1'b0;
      pkt_in = '0;
      mem_req_ack_i = 1'b1;
      step();
      mem_req_ack_i = 1'b0;
      chk("rw_in_wait", {pkt_in_ready, mem_req_o, pkt_out_valid}, 3'b000);
      #2 rst = 1'b1;
      #1;
      chk("rw_in_ready", pkt_in_ready, 1);
      chk("rw_out", {pkt_out_valid, pkt_out}, 0);
      chk("rw_mem", {mem_req_o, mem_cmd_o, mem_width_o, mem_addr_o, mem_wdata_o}, 0);
      step();
      rst = 1'b0;
      mem_resp_i = 2'd1;
      mem_rdata_i = 32'h99999999;
      step();
      mem_resp_i = 2'd0;
      mem_rdata_i = '0;
      for (int k = 0; k < 3; k++) begin
         chk("rw_no_rsp", {pkt_out_valid, mem_req_o, pkt_in_ready}, 3'b001);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
